// File: rtl/reaction_timer_if.sv
// Reaction timer bus: light pattern, 1 ms tick and button in; result and status out.
//   lights      - start-light pattern, 8'h00 = all lights off
//   tick        - one-cycle 1 ms strobe
//   btn         - driver button level, high when pressed
//   reaction_ms - last measured reaction time in ticks
//   valid       - reaction_ms holds a good measurement
//   jump_start  - button pressed before lights out
//   timeout     - no press within the limit after lights out
//   busy        - a measurement is armed or in progress
// master: the stimulus side (sequencer/driver); slave: the timer.
interface reaction_timer_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    logic [7:0]           lights;
    logic                 tick;
    logic                 btn;
    logic [CNT_WIDTH-1:0] reaction_ms;
    logic                 valid;
    logic                 jump_start;
    logic                 timeout;
    logic                 busy;

    modport master (
        output lights, tick, btn,
        input  reaction_ms, valid, jump_start, timeout, busy
    );

    modport slave (
        input  lights, tick, btn,
        output reaction_ms, valid, jump_start, timeout, busy
    );
endinterface

// File: rtl/reaction_timer.sv
// Reaction timer: measures ticks from lights-out to the first button press.
// Ports:
//   clk - single clock, all state updates on its rising edge
//   rst - synchronous active-low reset
//   bus - reaction_timer_if slave (lights/tick/btn in; reaction_ms/valid/
//         jump_start/timeout/busy out)
// Outputs are registered and hold from DONE through IDLE until the next
// sequence starts (IDLE -> ARMED clears them).
module reaction_timer #(
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned MAX_MS    = 9999
) (
    input logic            clk,
    input logic            rst,
    reaction_timer_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] MaxCnt = CNT_WIDTH'(MAX_MS);
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StArmed, StTiming, StDone} state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] reaction_q, reaction_d;
    logic                 valid_q, valid_d;
    logic                 jump_q, jump_d;
    logic                 timeout_q, timeout_d;
    logic                 btn_q;
    logic                 press;
    logic                 lights_off;

    // Rising edge only, so a held button counts once.
    assign press      = bus.btn & ~btn_q;
    assign lights_off = (bus.lights == 8'h00);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        reaction_d = reaction_q;
        valid_d    = valid_q;
        jump_d     = jump_q;
        timeout_d  = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (!lights_off) begin
                    state_d    = StArmed;
                    reaction_d = '0;
                    valid_d    = 1'b0;
                    jump_d     = 1'b0;
                    timeout_d  = 1'b0;
                end
            end
            StArmed: begin
                // A press wins even if the lights go out in the same cycle.
                if (press) begin
                    jump_d  = 1'b1;
                    state_d = StDone;
                end else if (lights_off) begin
                    cnt_d   = '0;
                    state_d = StTiming;
                end
            end
            StTiming: begin
                // Press captures the pre-increment count and beats tick/timeout.
                if (press) begin
                    reaction_d = cnt_q;
                    valid_d    = 1'b1;
                    state_d    = StDone;
                end else if (bus.tick) begin
                    if (cnt_q == MaxCnt) begin
                        reaction_d = MaxCnt;
                        timeout_d  = 1'b1;
                        valid_d    = 1'b0;
                        state_d    = StDone;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
            end
            StDone: begin
                if (!bus.btn && lights_off) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            btn_q      <= 1'b0;
            reaction_q <= '0;
            valid_q    <= 1'b0;
            jump_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            btn_q      <= bus.btn;
            reaction_q <= reaction_d;
            valid_q    <= valid_d;
            jump_q     <= jump_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.reaction_ms = reaction_q;
    assign bus.valid       = valid_q;
    assign bus.jump_start  = jump_q;
    assign bus.timeout     = timeout_q;
    assign bus.busy        = (state_q == StArmed) || (state_q == StTiming);
endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer: dut_a uses the default limit, dut_b a
// limit of 20 ticks for the timeout case.
module tb_reaction_timer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    reaction_timer_if #(.CNT_WIDTH(16)) bus_a ();
    reaction_timer_if #(.CNT_WIDTH(16)) bus_b ();

    reaction_timer #(.CNT_WIDTH(16), .MAX_MS(9999)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    reaction_timer #(.CNT_WIDTH(16), .MAX_MS(20)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int r, input int v, input int j,
                         input int t, input int b);
        chk({tag, ".reaction_ms"}, 32'(bus_a.reaction_ms), r);
        chk({tag, ".valid"},       32'(bus_a.valid),       v);
        chk({tag, ".jump_start"},  32'(bus_a.jump_start),  j);
        chk({tag, ".timeout"},     32'(bus_a.timeout),     t);
        chk({tag, ".busy"},        32'(bus_a.busy),        b);
    endtask

    task automatic chk_b(input string tag, input int r, input int v, input int j,
                         input int t, input int b);
        chk({tag, ".reaction_ms"}, 32'(bus_b.reaction_ms), r);
        chk({tag, ".valid"},       32'(bus_b.valid),       v);
        chk({tag, ".jump_start"},  32'(bus_b.jump_start),  j);
        chk({tag, ".timeout"},     32'(bus_b.timeout),     t);
        chk({tag, ".busy"},        32'(bus_b.busy),        b);
    endtask

    initial begin
        logic [7:0] ramp;
        bus_a.lights = 8'h00; bus_a.tick = 1'b0; bus_a.btn = 1'b0;
        bus_b.lights = 8'h00; bus_b.tick = 1'b0; bus_b.btn = 1'b0;

        // Reset
        rst = 1'b0;
        cyc();
        chk_a("reset_a", 0, 0, 0, 0, 0);
        chk_b("reset_b", 0, 0, 0, 0, 0);
        rst = 1'b1;
        cyc();

        // Normal run: ramp, lights out, 237 ticks, press
        ramp = 8'h01;
        bus_a.lights = ramp;
        cyc();
        chk_a("armed", 0, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) begin
            ramp = {ramp[6:0], 1'b1};
            bus_a.lights = ramp;
            cyc();
        end
        chk_a("ramp_ff", 0, 0, 0, 0, 1);
        bus_a.lights = 8'h00;
        cyc();
        chk_a("timing", 0, 0, 0, 0, 1);
        for (int i = 0; i < 237; i++) begin
            bus_a.tick = 1'b1;
            cyc();
        end
        bus_a.tick = 1'b0;
        chk_a("pre_press", 0, 0, 0, 0, 1);
        bus_a.btn = 1'b1;
        cyc();
        chk_a("press_237", 237, 1, 0, 0, 0);
        bus_a.btn = 1'b0;
        cyc();
        cyc();
        chk_a("hold_idle", 237, 1, 0, 0, 0);
        bus_a.lights = 8'h01;
        cyc();
        chk_a("clear_on_arm", 0, 0, 0, 0, 1);

        // Jump start at lights 7F, DONE held while btn held
        bus_a.lights = 8'h7F;
        cyc();
        bus_a.btn = 1'b1;
        cyc();
        chk_a("jump", 0, 0, 1, 0, 0);
        bus_a.lights = 8'h00;
        cyc();
        bus_a.lights = 8'h01;
        cyc();
        chk_a("done_btn_held", 0, 0, 1, 0, 0);
        bus_a.btn = 1'b0;
        cyc();
        chk_a("done_lights_on", 0, 0, 1, 0, 0);
        bus_a.lights = 8'h00;
        cyc();
        chk_a("idle_after_jump", 0, 0, 1, 0, 0);
        bus_a.lights = 8'h01;
        cyc();
        chk_a("rearm", 0, 0, 0, 0, 1);

        // Lights out and press in the same cycle while ARMED
        bus_a.lights = 8'h00;
        bus_a.btn = 1'b1;
        cyc();
        chk_a("out_and_press", 0, 0, 1, 0, 0);
        bus_a.btn = 1'b0;
        cyc();

        // Tick and press in the same cycle at count 5
        bus_a.lights = 8'h01;
        cyc();
        bus_a.lights = 8'h00;
        cyc();
        for (int i = 0; i < 5; i++) begin
            bus_a.tick = 1'b1;
            cyc();
        end
        bus_a.btn = 1'b1;
        cyc();
        bus_a.tick = 1'b0;
        chk_a("tick_press_5", 5, 1, 0, 0, 0);
        bus_a.btn = 1'b0;
        cyc();

        // Timeout on dut_b (limit 20): 20 ticks still timing, 21st times out
        bus_b.lights = 8'h03;
        cyc();
        bus_b.lights = 8'h00;
        cyc();
        for (int i = 0; i < 20; i++) begin
            bus_b.tick = 1'b1;
            cyc();
        end
        bus_b.tick = 1'b0;
        chk_b("b_at_limit", 0, 0, 0, 0, 1);
        bus_b.tick = 1'b1;
        cyc();
        bus_b.tick = 1'b0;
        chk_b("b_timeout", 20, 0, 0, 1, 0);
        cyc();
        chk_b("b_timeout_hold", 20, 0, 0, 1, 0);

        // Reset during TIMING at count 100
        bus_a.lights = 8'h01;
        cyc();
        bus_a.lights = 8'h00;
        cyc();
        for (int i = 0; i < 100; i++) begin
            bus_a.tick = 1'b1;
            cyc();
        end
        bus_a.tick = 1'b0;
        bus_a.btn = 1'b1;  // held across reset release
        rst = 1'b0;
        cyc();
        chk_a("mid_reset", 0, 0, 0, 0, 0);
        chk_b("b_mid_reset", 0, 0, 0, 0, 0);
        rst = 1'b1;
        cyc();
        chk_a("idle_ignores_press", 0, 0, 0, 0, 0);
        // Button still held: no new edge, so ARMED must not jump-start
        bus_a.lights = 8'h01;
        cyc();
        chk_a("held_btn_armed", 0, 0, 0, 0, 1);
        bus_a.btn = 1'b0;
        bus_a.lights = 8'h00;
        cyc();
        for (int i = 0; i < 42; i++) begin
            bus_a.tick = 1'b1;
            cyc();
        end
        bus_a.tick = 1'b0;
        bus_a.btn = 1'b1;
        cyc();
        chk_a("after_reset_42", 42, 1, 0, 0, 0);
        bus_a.btn = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
